// File: rtl/lsu_memprep_stage_if.sv
// ============================================================================
// Module      : lsu_memprep_stage_if
// Description : Data-memory request/response port of the MEMPREP load/store unit
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lsu_memprep_stage_if;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic [31:0] dmem_addr;
  logic        dmem_we;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic        dmem_rsp_valid;

  modport master (
    output dmem_req_valid, dmem_addr, dmem_we, dmem_wstrb, dmem_wdata,
    input  dmem_req_ready, dmem_rsp_valid
  );

  modport slave (
    input  dmem_req_valid, dmem_addr, dmem_we, dmem_wstrb, dmem_wdata,
    output dmem_req_ready, dmem_rsp_valid
  );
endinterface

`default_nettype wire

// File: rtl/lsu_memprep_stage.sv
// ============================================================================
// Module      : lsu_memprep_stage
// Description : MEMPREP load/store issue: builds data-memory requests, splits
//               word-crossing accesses, bounds outstanding requests
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_memprep_stage #(
  parameter logic [1:0]  RD_SEL_LSU         = 2'd1,
  parameter bit          SUPPORT_MISALIGNED = 1'b1,
  parameter int unsigned MAX_OUTSTANDING    = 2
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        invalid_MEMPREP,
  input  wire logic [31:0] alu_result_MEMPREP,
  input  wire logic [31:0] rs2_data_MEMPREP,
  input  wire logic        lsu_we_MEMPREP,
  input  wire logic [1:0]  rd_data_sel_MEMPREP,
  input  wire logic [1:0]  data_width_MEMPREP,
  input  wire logic        lsu_sign_extend_MEMPREP,
  lsu_memprep_stage_if.master dmem,
  output logic             stall_MEMPREP,
  output logic             valid_MEM,
  output logic             load_MEM,
  output logic             split_MEM,
  output logic             misaligned_MEM,
  output logic             sign_extend_MEM,
  output logic [1:0]       byte_offset_MEM,
  output logic [1:0]       data_width_MEM
);

  localparam logic [2:0] c_max_outstanding = 3'(MAX_OUTSTANDING);

  typedef enum logic [0:0] {
    C_PART0 = 1'b0,
    C_PART1 = 1'b1
  } part_t;

  part_t       r_part;
  logic [2:0]  r_cnt;

  logic        w_access;
  logic [1:0]  w_off;
  logic [3:0]  w_mask;
  logic        w_misaligned;
  logic        w_cross;
  logic        w_unsup;
  logic [7:0]  w_strb_wide;
  logic [63:0] w_data_wide;
  logic        w_issue_ok;
  logic        w_req_valid;
  logic        w_accept;
  logic        w_final_accept;
  logic        w_dec;

  assign w_access = !invalid_MEMPREP &&
                    (lsu_we_MEMPREP || (rd_data_sel_MEMPREP == RD_SEL_LSU));
  assign w_off    = alu_result_MEMPREP[1:0];

  always_comb begin
    w_mask       = 4'b1111;
    w_misaligned = (w_off != 2'd0);
    w_cross      = (w_off != 2'd0);
    case (data_width_MEMPREP)
      2'b00: begin
        w_mask       = 4'b0001;
        w_misaligned = 1'b0;
        w_cross      = 1'b0;
      end
      2'b01: begin
        w_mask       = 4'b0011;
        w_misaligned = w_off[0];
        w_cross      = (w_off == 2'd3);
      end
      default: ;
    endcase
  end

  // Upper halves of the shifted lane vectors are exactly the part-1 strobes/data.
  assign w_strb_wide = {4'b0000, w_mask} << w_off;
  assign w_data_wide = {32'd0, rs2_data_MEMPREP} << {w_off, 3'b000};

  assign w_unsup        = w_misaligned && !SUPPORT_MISALIGNED;
  assign w_issue_ok     = (r_cnt < c_max_outstanding) || dmem.dmem_rsp_valid;
  assign w_req_valid    = w_access && w_issue_ok && !w_unsup && !rst;
  assign w_accept       = w_req_valid && dmem.dmem_req_ready;
  assign w_final_accept = w_accept && ((r_part == C_PART1) || !w_cross);
  assign w_dec          = dmem.dmem_rsp_valid && (r_cnt != 3'd0);

  assign dmem.dmem_req_valid = w_req_valid;
  assign dmem.dmem_we        = w_access && lsu_we_MEMPREP && !rst;
  assign dmem.dmem_addr      = {alu_result_MEMPREP[31:2], 2'b00} +
                               ((r_part == C_PART1) ? 32'd4 : 32'd0);
  assign dmem.dmem_wstrb     = (r_part == C_PART1) ? w_strb_wide[7:4] : w_strb_wide[3:0];
  assign dmem.dmem_wdata     = !lsu_we_MEMPREP     ? 32'd0 :
                               (r_part == C_PART1) ? w_data_wide[63:32] :
                                                     w_data_wide[31:0];

  assign stall_MEMPREP = w_access && !w_final_accept && !w_unsup && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_part <= C_PART0;
    end else if (w_accept) begin
      r_part <= ((r_part == C_PART0) && w_cross) ? C_PART1 : C_PART0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 3'd0;
    end else if (w_accept && !w_dec) begin
      r_cnt <= r_cnt + 3'd1;
    end else if (!w_accept && w_dec) begin
      r_cnt <= r_cnt - 3'd1;
    end
  end

  // Metadata for the MEM-stage aligner; held between captures, only valid_MEM pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_MEM       <= 1'b0;
      load_MEM        <= 1'b0;
      split_MEM       <= 1'b0;
      misaligned_MEM  <= 1'b0;
      sign_extend_MEM <= 1'b0;
      byte_offset_MEM <= 2'd0;
      data_width_MEM  <= 2'd0;
    end else if (w_final_accept || (w_access && w_unsup)) begin
      valid_MEM       <= 1'b1;
      load_MEM        <= !lsu_we_MEMPREP;
      split_MEM       <= w_cross && SUPPORT_MISALIGNED;
      misaligned_MEM  <= w_unsup;
      sign_extend_MEM <= lsu_sign_extend_MEMPREP;
      byte_offset_MEM <= w_off;
      data_width_MEM  <= data_width_MEMPREP;
    end else begin
      valid_MEM       <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lsu_memprep_stage.sv
// ============================================================================
// Module      : tb_lsu_memprep_stage
// Description : Directed vector bench for lsu_memprep_stage
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_memprep_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        inv, we, sext, ready, rsp;
  logic [1:0]  sel, width;
  logic [31:0] addr, rs2;

  logic        stall0, v0, ld0, sp0, mis0, se0;
  logic [1:0]  off0, w0;
  logic        stall1, v1, ld1, sp1, mis1, se1;
  logic [1:0]  off1, w1;

  int checks = 0;
  int errors = 0;

  lsu_memprep_stage_if if0 ();
  lsu_memprep_stage_if if1 ();

  assign if0.dmem_req_ready = ready;
  assign if0.dmem_rsp_valid = rsp;
  assign if1.dmem_req_ready = ready;
  assign if1.dmem_rsp_valid = rsp;

  always #5 clk = ~clk;

  lsu_memprep_stage dut0 (
    .clk(clk), .rst(rst), .invalid_MEMPREP(inv), .alu_result_MEMPREP(addr),
    .rs2_data_MEMPREP(rs2), .lsu_we_MEMPREP(we), .rd_data_sel_MEMPREP(sel),
    .data_width_MEMPREP(width), .lsu_sign_extend_MEMPREP(sext), .dmem(if0),
    .stall_MEMPREP(stall0), .valid_MEM(v0), .load_MEM(ld0), .split_MEM(sp0),
    .misaligned_MEM(mis0), .sign_extend_MEM(se0), .byte_offset_MEM(off0),
    .data_width_MEM(w0)
  );

  lsu_memprep_stage #(.SUPPORT_MISALIGNED(1'b0)) dut1 (
    .clk(clk), .rst(rst), .invalid_MEMPREP(inv), .alu_result_MEMPREP(addr),
    .rs2_data_MEMPREP(rs2), .lsu_we_MEMPREP(we), .rd_data_sel_MEMPREP(sel),
    .data_width_MEMPREP(width), .lsu_sign_extend_MEMPREP(sext), .dmem(if1),
    .stall_MEMPREP(stall1), .valid_MEM(v1), .load_MEM(ld1), .split_MEM(sp1),
    .misaligned_MEM(mis1), .sign_extend_MEM(se1), .byte_offset_MEM(off1),
    .data_width_MEM(w1)
  );

  typedef struct {
    logic        inv, we;
    logic [1:0]  sel, width;
    logic [31:0] addr, rs2;
    logic        exp_valid, exp_stall, chk_bus;
    logic [31:0] exp_addr;
    logic        exp_we;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    logic        exp_vmem;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_acc(input logic i_inv, input logic i_we, input logic [1:0] i_sel,
                         input logic [1:0] i_w, input logic [31:0] i_a, input logic [31:0] i_d);
    inv = i_inv; we = i_we; sel = i_sel; width = i_w; addr = i_a; rs2 = i_d;
  endtask

  task automatic idle_drain(input int n);
    set_acc(1'b1, 1'b0, 2'd0, 2'd0, 32'd0, 32'd0);
    rsp = 1'b1;
    repeat (n) step();
    rsp = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b0,1'b1,2'd0,2'd2,32'h100,32'hDEADBEEF, 1'b1,1'b0,1'b1,32'h100,1'b1,4'b1111,32'hDEADBEEF,1'b1};
    vecs[1]  = '{1'b0,1'b1,2'd0,2'd0,32'h102,32'h000000AB, 1'b1,1'b0,1'b1,32'h100,1'b1,4'b0100,32'h00AB0000,1'b1};
    vecs[2]  = '{1'b0,1'b1,2'd0,2'd1,32'h102,32'h00001234, 1'b1,1'b0,1'b1,32'h100,1'b1,4'b1100,32'h12340000,1'b1};
    vecs[3]  = '{1'b0,1'b1,2'd0,2'd0,32'h103,32'h123456CD, 1'b1,1'b0,1'b1,32'h100,1'b1,4'b1000,32'hCD000000,1'b1};
    vecs[4]  = '{1'b0,1'b0,2'd1,2'd2,32'h200,32'hFFFFFFFF, 1'b1,1'b0,1'b1,32'h200,1'b0,4'b1111,32'h0,1'b1};
    vecs[5]  = '{1'b0,1'b0,2'd1,2'd1,32'h202,32'hFFFFFFFF, 1'b1,1'b0,1'b1,32'h200,1'b0,4'b1100,32'h0,1'b1};
    vecs[6]  = '{1'b0,1'b0,2'd1,2'd0,32'h201,32'hFFFFFFFF, 1'b1,1'b0,1'b1,32'h200,1'b0,4'b0010,32'h0,1'b1};
    vecs[7]  = '{1'b1,1'b1,2'd0,2'd2,32'h100,32'h11111111, 1'b0,1'b0,1'b0,32'h0,1'b0,4'b0,32'h0,1'b0};
    vecs[8]  = '{1'b0,1'b0,2'd0,2'd2,32'h104,32'h22222222, 1'b0,1'b0,1'b0,32'h0,1'b0,4'b0,32'h0,1'b0};
    vecs[9]  = '{1'b0,1'b1,2'd0,2'd3,32'h7FC,32'h01020304, 1'b1,1'b0,1'b1,32'h7FC,1'b1,4'b1111,32'h01020304,1'b1};
    vecs[10] = '{1'b0,1'b1,2'd0,2'd1,32'h100,32'h00005678, 1'b1,1'b0,1'b1,32'h100,1'b1,4'b0011,32'h00005678,1'b1};
    vecs[11] = '{1'b0,1'b1,2'd0,2'd1,32'h101,32'h0000BEEF, 1'b1,1'b0,1'b1,32'h100,1'b1,4'b0110,32'h00BEEF00,1'b1};
    vecs[12] = '{1'b1,1'b0,2'd1,2'd2,32'h300,32'h0,        1'b0,1'b0,1'b0,32'h0,1'b0,4'b0,32'h0,1'b0};

    // Reset with a live store on the inputs: outputs must stay quiet.
    rst = 1'b1; sext = 1'b0; ready = 1'b1; rsp = 1'b0;
    set_acc(1'b0, 1'b1, 2'd0, 2'd2, 32'h100, 32'h55AA55AA);
    step();
    #2;
    chk("rst.req_valid", if0.dmem_req_valid, 1'b0);
    chk("rst.stall", stall0, 1'b0);
    step();
    chk("rst.valid_MEM", v0, 1'b0);
    chk("rst.load_MEM", ld0, 1'b0);
    chk("rst.split_MEM", sp0, 1'b0);
    chk("rst.misaligned_MEM", mis0, 1'b0);
    chk("rst.sign_extend_MEM", se0, 1'b0);
    chk("rst.byte_offset_MEM", off0, 2'd0);
    chk("rst.data_width_MEM", w0, 2'd0);
    rst = 1'b0;

    // Misaligned-unsupported instance: lw 0x103 is flagged, no request issued.
    ready = 1'b0; sext = 1'b1;
    set_acc(1'b0, 1'b0, 2'd1, 2'd2, 32'h103, 32'h0);
    #2;
    chk("nomis.req_valid", if1.dmem_req_valid, 1'b0);
    chk("nomis.stall", stall1, 1'b0);
    step();
    chk("nomis.valid_MEM", v1, 1'b1);
    chk("nomis.misaligned_MEM", mis1, 1'b1);
    chk("nomis.byte_offset_MEM", off1, 2'd3);
    chk("nomis.load_MEM", ld1, 1'b1);
    chk("nomis.sign_extend_MEM", se1, 1'b1);
    set_acc(1'b0, 1'b0, 2'd1, 2'd2, 32'h200, 32'h0);
    #2;
    chk("nomis.aligned_req_valid", if1.dmem_req_valid, 1'b1);
    chk("nomis.aligned_stall", stall1, 1'b1);
    sext = 1'b0;

    // Single-cycle access table.
    ready = 1'b1; rsp = 1'b1;
    for (int i = 0; i < 13; i++) begin
      set_acc(vecs[i].inv, vecs[i].we, vecs[i].sel, vecs[i].width, vecs[i].addr, vecs[i].rs2);
      #2;
      chk($sformatf("v%0d.req_valid", i), if0.dmem_req_valid, vecs[i].exp_valid);
      chk($sformatf("v%0d.stall", i), stall0, vecs[i].exp_stall);
      if (vecs[i].chk_bus) begin
        chk($sformatf("v%0d.addr", i), if0.dmem_addr, vecs[i].exp_addr);
        chk($sformatf("v%0d.we", i), if0.dmem_we, vecs[i].exp_we);
        chk($sformatf("v%0d.wstrb", i), if0.dmem_wstrb, vecs[i].exp_strb);
        chk($sformatf("v%0d.wdata", i), if0.dmem_wdata, vecs[i].exp_wdata);
      end
      step();
      chk($sformatf("v%0d.valid_MEM", i), v0, vecs[i].exp_vmem);
    end
    idle_drain(2);

    // lw 0x103 splits into two requests.
    set_acc(1'b0, 1'b0, 2'd1, 2'd2, 32'h103, 32'h0);
    #2;
    chk("lwsplit.p0_addr", if0.dmem_addr, 32'h100);
    chk("lwsplit.p0_strb", if0.dmem_wstrb, 4'b1000);
    chk("lwsplit.p0_stall", stall0, 1'b1);
    chk("lwsplit.p0_valid", if0.dmem_req_valid, 1'b1);
    step();
    chk("lwsplit.p0_valid_MEM", v0, 1'b0);
    #2;
    chk("lwsplit.p1_addr", if0.dmem_addr, 32'h104);
    chk("lwsplit.p1_strb", if0.dmem_wstrb, 4'b0111);
    chk("lwsplit.p1_stall", stall0, 1'b0);
    step();
    chk("lwsplit.valid_MEM", v0, 1'b1);
    chk("lwsplit.split_MEM", sp0, 1'b1);
    chk("lwsplit.byte_offset_MEM", off0, 2'd3);
    chk("lwsplit.load_MEM", ld0, 1'b1);
    idle_drain(2);

    // sw crossing the top of the address space: part 1 wraps to 0.
    set_acc(1'b0, 1'b1, 2'd0, 2'd2, 32'hFFFFFFFD, 32'hAABBCCDD);
    #2;
    chk("swsplit.p0_addr", if0.dmem_addr, 32'hFFFFFFFC);
    chk("swsplit.p0_strb", if0.dmem_wstrb, 4'b1110);
    chk("swsplit.p0_wdata", if0.dmem_wdata, 32'hBBCCDD00);
    step();
    chk("swsplit.p1_addr", if0.dmem_addr, 32'h0);
    chk("swsplit.p1_strb", if0.dmem_wstrb, 4'b0001);
    chk("swsplit.p1_wdata", if0.dmem_wdata, 32'h000000AA);
    chk("swsplit.p1_we", if0.dmem_we, 1'b1);
    step();
    chk("swsplit.valid_MEM", v0, 1'b1);
    chk("swsplit.load_MEM", ld0, 1'b0);
    idle_drain(2);

    // Backpressure for 3 cycles, then outstanding limit with MAX=2.
    ready = 1'b0;
    set_acc(1'b0, 1'b0, 2'd1, 2'd2, 32'h200, 32'h0);
    for (int c = 0; c < 3; c++) begin
      #2;
      chk($sformatf("bp%0d.req_valid", c), if0.dmem_req_valid, 1'b1);
      chk($sformatf("bp%0d.addr", c), if0.dmem_addr, 32'h200);
      chk($sformatf("bp%0d.stall", c), stall0, 1'b1);
      step();
      chk($sformatf("bp%0d.valid_MEM", c), v0, 1'b0);
    end
    ready = 1'b1;
    #2;
    chk("bp.accept_stall", stall0, 1'b0);
    step();
    chk("bp.valid_MEM", v0, 1'b1);
    set_acc(1'b0, 1'b0, 2'd1, 2'd2, 32'h300, 32'h0);
    #2;
    chk("max.second_req_valid", if0.dmem_req_valid, 1'b1);
    chk("max.second_stall", stall0, 1'b0);
    step();
    set_acc(1'b0, 1'b0, 2'd1, 2'd2, 32'h304, 32'h0);
    for (int c = 0; c < 2; c++) begin
      #2;
      chk($sformatf("max.blocked%0d_req_valid", c), if0.dmem_req_valid, 1'b0);
      chk($sformatf("max.blocked%0d_stall", c), stall0, 1'b1);
      step();
    end
    rsp = 1'b1;
    #2;
    chk("max.rsp_req_valid", if0.dmem_req_valid, 1'b1);
    chk("max.rsp_addr", if0.dmem_addr, 32'h304);
    chk("max.rsp_stall", stall0, 1'b0);
    step();
    chk("max.valid_MEM", v0, 1'b1);
    rsp = 1'b0;
    idle_drain(3);

    // Reset while part 1 of a split is pending.
    set_acc(1'b0, 1'b0, 2'd1, 2'd2, 32'h103, 32'h0);
    step();
    rst = 1'b1;
    #2;
    chk("rstsplit.req_valid", if0.dmem_req_valid, 1'b0);
    chk("rstsplit.stall", stall0, 1'b0);
    step();
    chk("rstsplit.valid_MEM", v0, 1'b0);
    rst = 1'b0;
    set_acc(1'b0, 1'b0, 2'd1, 2'd2, 32'h200, 32'h0);
    #2;
    chk("rstsplit.new_addr", if0.dmem_addr, 32'h200);
    chk("rstsplit.new_strb", if0.dmem_wstrb, 4'b1111);
    chk("rstsplit.new_stall", stall0, 1'b0);
    step();
    chk("rstsplit.new_valid_MEM", v0, 1'b1);
    chk("rstsplit.new_split_MEM", sp0, 1'b0);
    set_acc(1'b0, 1'b0, 2'd1, 2'd2, 32'h204, 32'h0);
    #2;
    chk("rstsplit.cnt_second_req", if0.dmem_req_valid, 1'b1);
    step();
    set_acc(1'b0, 1'b0, 2'd1, 2'd2, 32'h208, 32'h0);
    #2;
    chk("rstsplit.cnt_third_req", if0.dmem_req_valid, 1'b0);
    set_acc(1'b1, 1'b0, 2'd0, 2'd0, 32'd0, 32'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
